// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding, error codes and
// the load-count legality check used when a load is requested.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OK    = 2'd0,
    ZERO  = 2'd1,
    OVER  = 2'd2,
    ABORT = 2'd3
  } err_t;

  function automatic err_t count_check(input logic [15:0] count,
                                       input int unsigned max_words);
    if (count == 16'd0) return ZERO;
    if (32'(count) > max_words) return OVER;
    return OK;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte assembler: each accepted byte lands in the next byte
// lane of a 32-bit word; word_full flags the fourth byte of a word.
module byte_packer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0] idx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (accept) begin
      word[{idx, 3'b000} +: 8] <= byte_data;
      idx                      <= idx + 2'd1;
    end
  end

  // The index wraps to 0 on its own after the fourth byte.
  assign word_full = accept && (idx == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Instruction-memory writer: packs a byte stream into words, writes them to
// consecutive addresses while holding the core in reset, then releases it.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter logic [31:0] WORD_STEP = 32'd4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load_start,
  input  logic [15:0] load_word_count,
  input  logic        load_abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        load_memory_write,
  output logic [31:0] load_memory_a,
  output logic [31:0] load_memory_v,
  output logic        core_hold,
  output logic        load_busy,
  output logic        load_done,
  output logic [1:0]  load_error
);

  state_t      state, nxt_state;
  err_t        err_q, nxt_err;
  err_t        start_err;
  logic [15:0] count_q;
  logic [15:0] word_cnt;
  logic [31:0] addr_q;
  logic        word_full;
  logic [31:0] packed_word;
  logic        can_start;
  logic        start_go;
  logic        last_word;
  logic        accept;

  assign start_err = count_check(load_word_count, MAX_WORDS);
  assign can_start = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign start_go  = can_start && load_start && (start_err == OK);
  assign last_word = ((word_cnt + 16'd1) == count_q);
  assign accept    = byte_valid && byte_ready;

  byte_packer u_packer (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (start_go),
    .accept    (accept),
    .byte_data (byte_data),
    .word_full (word_full),
    .word      (packed_word)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      err_q <= OK;
    end else begin
      state <= nxt_state;
      err_q <= nxt_err;
    end
  end

  // Abort outranks everything in the active states; load_start is only
  // honoured from the resting states.
  always_comb begin
    nxt_state = state;
    nxt_err   = err_q;
    case (state)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          nxt_err = start_err;
          if (start_err == OK) nxt_state = COLLECT;
          else                 nxt_state = ERROR;
        end
      end
      COLLECT: begin
        if (load_abort) begin
          nxt_state = ERROR;
          nxt_err   = ABORT;
        end else if (word_full) begin
          nxt_state = WRITE;
        end
      end
      WRITE: begin
        if (load_abort) begin
          nxt_state = ERROR;
          nxt_err   = ABORT;
        end else if (last_word) begin
          nxt_state = DONE;
        end else begin
          nxt_state = COLLECT;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // The address only advances when another word follows, so DONE keeps
  // showing the last written address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q  <= 16'd0;
      word_cnt <= 16'd0;
      addr_q   <= LOAD_BASE;
    end else if (start_go) begin
      count_q  <= load_word_count;
      word_cnt <= 16'd0;
      addr_q   <= LOAD_BASE;
    end else if (state == WRITE && !load_abort) begin
      word_cnt <= word_cnt + 16'd1;
      if (!last_word) addr_q <= addr_q + WORD_STEP;
    end
  end

  always_comb begin
    byte_ready        = 1'b0;
    load_memory_write = 1'b0;
    load_busy         = 1'b0;
    core_hold         = 1'b0;
    load_done         = 1'b0;
    case (state)
      COLLECT: begin
        byte_ready = 1'b1;
        load_busy  = 1'b1;
        core_hold  = 1'b1;
      end
      WRITE: begin
        load_memory_write = 1'b1;
        load_busy         = 1'b1;
        core_hold         = 1'b1;
      end
      DONE:    load_done = 1'b1;
      ERROR:   core_hold = 1'b1;
      default: ;
    endcase
  end

  assign load_memory_a = addr_q;
  assign load_memory_v = packed_word;
  assign load_error    = err_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface: the core only reads instruction memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes each word to consecutive instruction-memory addresses while holding the core in reset.
- Releases the core when the requested word count has been written. Sits beside Core and Instruction_and_data in the top-level IO wrapper, on the same clock as Core.

Parameters:
- LOAD_BASE, 32'h0000_0000, byte address of the first word written.
- WORD_STEP, 4, address increment per word.
- MAX_WORDS, 1024, largest legal load_word_count.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a load; samples load_word_count.
- load_word_count  input  16  number of 32-bit words to load.
- load_abort  input  1  cancels an in-progress load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- load_memory_write  output  1  one-cycle instruction-memory write strobe.
- load_memory_a  output  32  write address.
- load_memory_v  output  32  write data.
- core_hold  output  1  ORed into Core Reset by the top level.
- load_busy  output  1  load in progress.
- load_done  output  1  last load completed successfully.
- load_error  output  2  00 ok, 01 zero count, 10 count > MAX_WORDS, 11 aborted.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - Outputs byte_ready, load_memory_write, core_hold, load_busy and load_done are 0.
  - load_memory_a = LOAD_BASE; load_memory_v = 0; load_error = 00.
  - Internal byte index = 0; word counter = 0.
- States are IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE, when load_start = 1:
  - If count = 0: go to ERROR with error code 01.
  - If count > MAX_WORDS: go to ERROR with error code 10.
  - Otherwise: latch count, set address = LOAD_BASE, clear byte index and word counter, clear load_done and load_error, go to COLLECT.
  - core_hold and load_busy go to 1 in the same edge.
- COLLECT:
  - byte_ready = 1 (registered, high throughout the state).
  - A byte is accepted on a cycle where byte_valid && byte_ready.
  - Byte index k (0..3) goes into bits [8k+7:8k] of the word register.
  - On the 4th accepted byte, go to WRITE.
  - byte_valid while byte_ready = 0 is ignored; no byte is consumed.
- WRITE (exactly 1 cycle):
  - load_memory_write = 1, with load_memory_a and load_memory_v stable.
  - byte_ready = 0.
  - On leaving, the address increments by WORD_STEP (32-bit wrap allowed, never reached in practice) and the word counter increments.
  - If word counter + 1 == count, go to DONE. Otherwise return to COLLECT.
  - Minimum cost is 5 cycles per word: 4 byte accepts plus 1 write.
- DONE:
  - core_hold = 0, load_busy = 0, load_done = 1.
  - load_memory_a holds the last written address.
  - load_start starts a new load as from IDLE.
- ERROR:
  - core_hold = 1, load_busy = 0, load_done = 0, load_error holds its code.
  - Exited only by a new load_start, evaluated as from IDLE, or by Reset.
- load_abort:
  - Acts in COLLECT or WRITE: next state is ERROR with code 11.
  - A write strobe already presented this cycle still completes.
  - Ignored in other states.
- Simultaneous events:
  - load_abort has priority over load_start.
  - load_start is ignored in COLLECT and WRITE.
- Partial word at abort is discarded; nothing is written.
- Reset mid-load returns everything to reset values. Memory already written is left as-is.

Decomposition:
- Shared package (loader_pkg):
  - State encoding localparams: IDLE = 0, COLLECT = 1, WRITE = 2, DONE = 3, ERROR = 4.
  - Error codes: OK, ZERO, OVER, ABORT.
- Optional sub-module byte_packer: byte index counter plus 32-bit shift/assemble register, with accept and clear inputs and a word_full output.
- The FSM, address counter and word counter stay in program_loader.

Test Plan:
- Reset asserted mid-COLLECT:
  - all outputs return to reset values immediately, without waiting for a Clk edge;
  - load_memory_a = 0.
- load_start with count = 2, bytes 78,56,34,12,EF,BE,AD,DE sent back-to-back:
  - write of 0x12345678 to address 0x0 at cycle 5, then 0xDEADBEEF to address 0x4 at cycle 10;
  - load_done = 1, core_hold = 0 afterward.
- count = 1 with byte_valid toggling every other cycle:
  - exactly 4 bytes consumed, one write;
  - byte_ready = 0 during the WRITE cycle.
- count = 0:
  - ERROR, load_error = 01, no write, core_hold = 1;
  - a following load_start with count = 1 recovers.
- count = 1025 (MAX_WORDS = 1024):
  - load_error = 10, no write.
- load_abort after 2 bytes of word 1:
  - ERROR, load_error = 11, no write for the partial word;
  - load_abort and load_start in the same cycle resolves as abort.
